down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_if.sv | 26 ++
 rtl/down_timer.sv | 97 +++++++++
 tb/tb_down_timer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/down_timer_if.sv
// Signal bundle between a down_timer and the logic that loads and controls it.
// The master side issues loads and control; the slave side is the timer itself.
interface down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic             enable;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  modport master (
    output load_valid, load_value, mode, enable, stop,
    input  load_ready, count, busy, done, tc_pulse
  );

  modport slave (
    input  load_valid, load_value, mode, enable, stop,
    output load_ready, count, busy, done, tc_pulse
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot and periodic modes, pause, abort and a
// registered one-cycle terminal-count strobe.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  down_timer_if.slave  tmr_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q,   mode_d;
  logic             tc_q,     tc_d;

  logic             load_ready;

  assign load_ready = (state_q != RUN);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (tmr_if.stop) begin
      // Abort wins over loads and over a terminal count due on this edge.
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (tmr_if.load_valid) begin
            state_d  = RUN;
            count_d  = tmr_if.load_value;
            reload_d = tmr_if.load_value;
            mode_d   = tmr_if.mode;
          end
        end
        RUN: begin
          if (tmr_if.enable) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                state_d = DONE;
                count_d = '0;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign tmr_if.load_ready = load_ready;
  assign tmr_if.count      = count_q;
  assign tmr_if.busy       = (state_q == RUN);
  assign tmr_if.done       = (state_q == DONE);
  assign tmr_if.tc_pulse   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a cycle model built from the timer's
// behavioural rules, compared every cycle, plus directed literal expectations.
module tb_down_timer;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  down_timer_if #(.WIDTH(WIDTH)) tmr_if ();

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tmr_if (tmr_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "is a countdown in progress", "has a one-shot finished",
  // and how many ticks remain before the terminal strobe.
  bit m_running, m_finished, m_periodic, m_tc;
  int m_count, m_reload;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 0; m_finished = 0; m_periodic = 0; m_tc = 0;
      m_count = 0; m_reload = 0;
    end else begin
      m_tc = 0;
      if (tmr_if.stop) begin
        m_running = 0; m_finished = 0; m_count = 0;
      end else if (!m_running) begin
        if (tmr_if.load_valid) begin
          m_running  = 1; m_finished = 0;
          m_count    = int'(tmr_if.load_value);
          m_reload   = m_count;
          m_periodic = tmr_if.mode;
        end
      end else if (tmr_if.enable) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (m_periodic) m_count = m_reload;
          else begin m_running = 0; m_finished = 1; end
        end
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  bit prev_tc = 0;
  always @(negedge clk) begin
    check("count",      32'(tmr_if.count),      32'(m_count));
    check("busy",       32'(tmr_if.busy),       32'(m_running));
    check("done",       32'(tmr_if.done),       32'(m_finished));
    check("load_ready", 32'(tmr_if.load_ready), 32'(!m_running));
    check("tc_pulse",   32'(tmr_if.tc_pulse),   32'(m_tc));
    if (prev_tc && tmr_if.tc_pulse)
      check("tc_back_to_back_allowed", 32'd1, 32'(m_periodic && m_reload == 0));
    prev_tc = tmr_if.tc_pulse;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int n, input bit md);
    tmr_if.load_valid = 1'b1;
    tmr_if.load_value = WIDTH'(n);
    tmr_if.mode       = md;
    tick();
    tmr_if.load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    tmr_if.load_valid = 1'b1;
    tmr_if.load_value = 4'd9;
    tmr_if.mode       = 1'b0;
    tmr_if.enable     = 1'b1;
    tmr_if.stop       = 1'b0;
    tick(3);
    check("rst_ignores_load_busy", 32'(tmr_if.busy), 32'd0);
    check("rst_count", 32'(tmr_if.count), 32'd0);

    // First edge after release accepts the load; one-shot N=3.
    rst_n = 1'b1;
    tmr_if.load_value = 4'd3;
    tick();
    tmr_if.load_valid = 1'b0;
    check("os_load_count", 32'(tmr_if.count), 32'd3);
    check("os_load_busy", 32'(tmr_if.busy), 32'd1);
    tick(3);
    check("os_count0", 32'(tmr_if.count), 32'd0);
    check("os_no_tc_yet", 32'(tmr_if.tc_pulse), 32'd0);
    tick();
    check("os_tc_edge4", 32'(tmr_if.tc_pulse), 32'd1);
    check("os_done_edge4", 32'(tmr_if.done), 32'd1);
    tick();
    check("os_tc_one_cycle", 32'(tmr_if.tc_pulse), 32'd0);
    check("os_done_hold", 32'(tmr_if.done), 32'd1);

    // Periodic N=2; load_value/mode changes mid-run are ignored.
    load(2, 1'b1);
    tmr_if.load_value = 4'd9;
    tmr_if.mode       = 1'b0;
    tick(2);
    check("per_count0", 32'(tmr_if.count), 32'd0);
    tick();
    check("per_tc", 32'(tmr_if.tc_pulse), 32'd1);
    check("per_reload", 32'(tmr_if.count), 32'd2);
    tick(3);
    check("per_tc2", 32'(tmr_if.tc_pulse), 32'd1);
    check("per_reload2", 32'(tmr_if.count), 32'd2);
    tmr_if.stop = 1'b1; tick(); tmr_if.stop = 1'b0;
    check("stop_idle", 32'(tmr_if.busy), 32'd0);

    // Pause: N=5, enable low for 4 cycles at count 3 -> tc after edge 10.
    load(5, 1'b0);
    tick(2);
    check("pause_at3", 32'(tmr_if.count), 32'd3);
    tmr_if.enable = 1'b0;
    tick(4);
    check("pause_hold", 32'(tmr_if.count), 32'd3);
    check("pause_no_tc", 32'(tmr_if.tc_pulse), 32'd0);
    tmr_if.enable = 1'b1;
    tick(3);
    check("pause_no_tc_early", 32'(tmr_if.tc_pulse), 32'd0);
    tick();
    check("pause_tc_delayed", 32'(tmr_if.tc_pulse), 32'd1);

    // N=0: tc after edge 1.
    load(0, 1'b0);
    check("n0_busy", 32'(tmr_if.busy), 32'd1);
    tick();
    check("n0_tc", 32'(tmr_if.tc_pulse), 32'd1);

    // N=15 with load_valid held during RUN: no restart.
    load(15, 1'b0);
    tmr_if.load_valid = 1'b1;
    tmr_if.load_value = 4'd7;
    tick(15);
    tmr_if.load_valid = 1'b0;
    check("n15_count0", 32'(tmr_if.count), 32'd0);
    tick();
    check("n15_tc_edge16", 32'(tmr_if.tc_pulse), 32'd1);

    // Periodic reload 0: strobe every enabled cycle.
    load(0, 1'b1);
    tick(3);
    check("per0_tc", 32'(tmr_if.tc_pulse), 32'd1);
    tmr_if.stop = 1'b1; tick(); tmr_if.stop = 1'b0;

    // Stop on the terminal-count edge: no tc, IDLE, count 0.
    load(1, 1'b1);
    tick();
    tmr_if.stop = 1'b1; tick(); tmr_if.stop = 1'b0;
    check("stop_tc_suppressed", 32'(tmr_if.tc_pulse), 32'd0);
    check("stop_tc_idle", 32'(tmr_if.busy), 32'd0);

    // Stop + load in DONE -> IDLE; stop in IDLE blocks a same-cycle load.
    load(0, 1'b0);
    tick();
    tmr_if.stop = 1'b1; tmr_if.load_valid = 1'b1; tmr_if.load_value = 4'd4;
    tick();
    check("stop_done_to_idle", 32'(tmr_if.done), 32'd0);
    check("stop_done_noload", 32'(tmr_if.busy), 32'd0);
    tick();
    check("stop_idle_blocks_load", 32'(tmr_if.busy), 32'd0);
    tmr_if.stop = 1'b0;
    tick();
    tmr_if.load_valid = 1'b0;
    check("load_after_stop", 32'(tmr_if.count), 32'd4);

    // Async reset mid-RUN at count 7, then a clean reload.
    tmr_if.stop = 1'b1; tick(); tmr_if.stop = 1'b0;
    load(9, 1'b0);
    tick(2);
    check("pre_rst_count7", 32'(tmr_if.count), 32'd7);
    #2 rst_n = 1'b0;
    tmr_if.load_valid = 1'b1;
    tmr_if.load_value = 4'd6;
    #1;
    check("arst_count", 32'(tmr_if.count), 32'd0);
    check("arst_busy", 32'(tmr_if.busy), 32'd0);
    check("arst_done", 32'(tmr_if.done), 32'd0);
    check("arst_tc", 32'(tmr_if.tc_pulse), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    tmr_if.load_valid = 1'b0;
    check("reload_after_rst", 32'(tmr_if.count), 32'd6);
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
